// File: rtl/fact_requester_if.sv
// Register-bus and accelerator-handshake signals of fact_requester.
// slave: the requester's view; master: the bus host / accelerator side.
interface fact_requester_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  WE;
  logic [1:0]            A;
  logic [DATA_WIDTH-1:0] WD;
  logic [DATA_WIDTH-1:0] RD;
  logic [3:0]            n_out;
  logic                  go;
  logic                  done_in;
  logic                  error_in;
  logic                  buf_oe;
  logic [DATA_WIDTH-1:0] result_in;
  logic                  busy;
  logic                  irq;

  modport slave (
    input  WE, A, WD, done_in, error_in, result_in,
    output RD, n_out, go, buf_oe, busy, irq
  );

  modport master (
    output WE, A, WD, done_in, error_in, result_in,
    input  RD, n_out, go, buf_oe, busy, irq
  );
endinterface

// File: rtl/fact_requester.sv
// Register-mapped requester: issues a start to a factorial accelerator,
// waits with a timeout for completion and captures the result.
module fact_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic            CLK,
  input logic            RST,
  fact_requester_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_READ} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  done_flag_q, done_flag_d;
  logic                  err_flag_q, err_flag_d;
  logic                  to_flag_q, to_flag_d;
  logic                  irq_en_q, irq_en_d;
  logic                  wr_ctrl;
  logic                  unused_wd;

  assign unused_wd = ^bus.WD[DATA_WIDTH-1:4];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      done_flag_q <= 1'b0;
      err_flag_q  <= 1'b0;
      to_flag_q   <= 1'b0;
      irq_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      done_flag_q <= done_flag_d;
      err_flag_q  <= err_flag_d;
      to_flag_q   <= to_flag_d;
      irq_en_q    <= irq_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    done_flag_d = done_flag_q;
    err_flag_d  = err_flag_q;
    to_flag_d   = to_flag_q;
    irq_en_d    = irq_en_q;
    wr_ctrl     = bus.WE && (bus.A == 2'd1);

    if (bus.WE && (bus.A == 2'd0) && (state_q == S_IDLE)) n_d = bus.WD[3:0];

    // Bus clear is applied first so a completion in the same cycle still sets its flag.
    if (wr_ctrl) begin
      irq_en_d = bus.WD[2];
      if (bus.WD[1]) begin
        done_flag_d = 1'b0;
        err_flag_d  = 1'b0;
        to_flag_d   = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl && bus.WD[0]) begin
          state_d     = S_ISSUE;
          done_flag_d = 1'b0;
          err_flag_d  = 1'b0;
          to_flag_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (bus.done_in) begin
          if (bus.error_in) begin
            err_flag_d  = 1'b1;
            done_flag_d = 1'b1;
            result_d    = '0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_READ;
          end
        end else if (cnt_q == CNT_LAST) begin
          to_flag_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_READ: begin
        result_d    = bus.result_in;
        done_flag_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.go     = (state_q == S_ISSUE);
  assign bus.buf_oe = (state_q == S_READ);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.n_out  = n_q;
  assign bus.irq    = (done_flag_q || err_flag_q || to_flag_q) && irq_en_q;

  always_comb begin
    bus.RD = '0;
    case (bus.A)
      2'd0: bus.RD[3:0] = n_q;
      2'd1: bus.RD[2]   = irq_en_q;
      2'd2: bus.RD[3:0] = {to_flag_q, err_flag_q, done_flag_q, (state_q != S_IDLE)};
      default: bus.RD = result_q;
    endcase
  end

endmodule

// File: tb/tb_fact_requester.sv
// Directed bench for fact_requester: stimulus queues expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_fact_requester;

  localparam int SEL_RD     = 0;
  localparam int SEL_BUSY   = 1;
  localparam int SEL_IRQ    = 2;
  localparam int SEL_GO     = 3;
  localparam int SEL_BOE    = 4;
  localparam int SEL_NOUT   = 5;
  localparam int SEL_GOCNT  = 6;
  localparam int SEL_BOECNT = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   go_cnt      = 0;
  int   boe_cnt     = 0;
  int   go_base;
  int   boe_base;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fact_requester_if #(.DATA_WIDTH(32)) bus();

  fact_requester #(.DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  exp_t        e;
  logic [31:0] act;

  always @(negedge clk) begin
    if (bus.go === 1'b1) go_cnt++;
    if (bus.buf_oe === 1'b1) boe_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RD:     act = bus.RD;
        SEL_BUSY:   act = {31'd0, bus.busy};
        SEL_IRQ:    act = {31'd0, bus.irq};
        SEL_GO:     act = {31'd0, bus.go};
        SEL_BOE:    act = {31'd0, bus.buf_oe};
        SEL_NOUT:   act = {28'd0, bus.n_out};
        SEL_GOCNT:  act = go_cnt;
        default:    act = boe_cnt;
      endcase
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [31:0] val);
    exp_t x;
    x.name = name;
    x.sel  = sel;
    x.val  = val;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.WE = 1'b1;
    bus.A  = a;
    bus.WD = d;
    tick();
    bus.WE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] v);
    bus.A = a;
    chk(name, SEL_RD, v);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.WE = 1'b0; bus.A = 2'd0; bus.WD = '0;
    bus.done_in = 1'b0; bus.error_in = 1'b0; bus.result_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_busy", SEL_BUSY, 0); chk("rst_irq", SEL_IRQ, 0);
    chk("rst_go", SEL_GO, 0); chk("rst_boe", SEL_BOE, 0); chk("rst_nout", SEL_NOUT, 0);
    rd("rst_n", 2'd0, 0); rd("rst_ctrl", 2'd1, 0); rd("rst_stat", 2'd2, 0); rd("rst_res", 2'd3, 0);

    // N=5 normal run, result 120
    wr(2'd0, 5);
    chk("n5_nout", SEL_NOUT, 5);
    go_base = go_cnt; boe_base = boe_cnt;
    wr(2'd1, 1);
    chk("n5_go", SEL_GO, 1); chk("n5_busy", SEL_BUSY, 1);
    tick(); tick();
    bus.done_in = 1'b1; bus.result_in = 120;
    tick();
    chk("n5_boe", SEL_BOE, 1); chk("n5_go_low", SEL_GO, 0);
    bus.done_in = 1'b0;
    tick();
    bus.result_in = '0;
    chk("n5_idle", SEL_BUSY, 0);
    rd("n5_res", 2'd3, 120); rd("n5_stat", 2'd2, 2);
    chk("n5_gocnt", SEL_GOCNT, go_base + 1); chk("n5_boecnt", SEL_BOECNT, boe_base + 1);

    // N=13 error run with irq enabled
    wr(2'd0, 13);
    boe_base = boe_cnt;
    wr(2'd1, 5);
    tick();
    bus.done_in = 1'b1; bus.error_in = 1'b1;
    tick();
    bus.done_in = 1'b0; bus.error_in = 1'b0;
    chk("err_idle", SEL_BUSY, 0); chk("err_irq", SEL_IRQ, 1);
    chk("err_noboe", SEL_BOECNT, boe_base);
    rd("err_res", 2'd3, 0); rd("err_stat", 2'd2, 6); rd("err_ctrl", 2'd1, 4);
    chk("err_irq_hold", SEL_IRQ, 1);
    wr(2'd1, 6);
    chk("err_irq_clr", SEL_IRQ, 0);
    rd("err_stat_clr", 2'd2, 0); rd("err_ctrl2", 2'd1, 4);

    // timeout: busy exactly 1+8 cycles after start edge
    go_base = go_cnt;
    wr(2'd1, 1);
    for (int i = 0; i < 9; i++) begin
      chk("to_busy", SEL_BUSY, 1);
      tick();
    end
    chk("to_idle", SEL_BUSY, 0);
    rd("to_stat", 2'd2, 8);
    chk("to_gocnt", SEL_GOCNT, go_base + 1);

    // restart and N write during WAIT are ignored
    wr(2'd0, 2);
    go_base = go_cnt;
    wr(2'd1, 1);
    tick();
    wr(2'd1, 1);
    wr(2'd0, 7);
    chk("ign_nout", SEL_NOUT, 2); chk("ign_busy", SEL_BUSY, 1);
    bus.done_in = 1'b1; bus.result_in = 2;
    tick();
    bus.done_in = 1'b0;
    tick();
    chk("ign_idle", SEL_BUSY, 0);
    rd("ign_n", 2'd0, 2); rd("ign_res", 2'd3, 2); rd("ign_stat", 2'd2, 2);
    chk("ign_gocnt", SEL_GOCNT, go_base + 1);

    // done_in on the last WAIT cycle beats the timeout
    wr(2'd1, 1);
    repeat (8) tick();
    bus.done_in = 1'b1; bus.result_in = 77;
    tick();
    chk("edge_boe", SEL_BOE, 1); chk("edge_busy", SEL_BUSY, 1);
    bus.done_in = 1'b0;
    tick();
    rd("edge_stat", 2'd2, 2); rd("edge_res", 2'd3, 77);

    // reset during READ drops buf_oe immediately
    wr(2'd0, 4);
    wr(2'd1, 1);
    tick();
    bus.done_in = 1'b1; bus.result_in = 24;
    tick();
    bus.done_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    if (bus.buf_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL rrst_boe_now: got %0b expected 0", bus.buf_oe);
    end
    chk("rrst_boe", SEL_BOE, 0); chk("rrst_busy", SEL_BUSY, 0);
    @(posedge clk); #1 rst = 1'b0;
    rd("rrst_res", 2'd3, 0); rd("rrst_n", 2'd0, 0);

    // reset during WAIT, then normal N=3 run
    wr(2'd0, 9);
    wr(2'd1, 1);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    if (bus.go !== 1'b0 || bus.busy !== 1'b0 || bus.buf_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL wrst_now: go=%0b busy=%0b buf_oe=%0b expected 0", bus.go, bus.busy, bus.buf_oe);
    end
    chk("wrst_go", SEL_GO, 0); chk("wrst_busy", SEL_BUSY, 0);
    chk("wrst_boe", SEL_BOE, 0); chk("wrst_nout", SEL_NOUT, 0);
    @(posedge clk); #1 rst = 1'b0;
    rd("wrst_n", 2'd0, 0); rd("wrst_ctrl", 2'd1, 0); rd("wrst_stat", 2'd2, 0); rd("wrst_res", 2'd3, 0);
    chk("wrst_irq", SEL_IRQ, 0);
    wr(2'd0, 3);
    wr(2'd1, 1);
    chk("n3_go", SEL_GO, 1);
    tick();
    bus.done_in = 1'b1; bus.result_in = 6;
    tick();
    bus.done_in = 1'b0;
    tick();
    rd("n3_res", 2'd3, 6); rd("n3_stat", 2'd2, 2); rd("n3_n", 2'd0, 3);

    tick(); tick();
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending: %0d expectations not checked, expected 0", exp_q.size());
    end
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL vectors: no vectors applied, expected some");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL %0d miscompares", miscompares);
    $finish;
  end

endmodule
